// File: rtl/mips_pkg.sv
// Shared MIPS memory-stage definitions: opcodes, FSM states, byte enables, MEM/WB payload.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [3:0] BE_WORD    = 4'hF;
  localparam logic [3:0] BE_LO_HALF = 4'h3;
  localparam logic [3:0] BE_HI_HALF = 4'hC;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] result;
    logic [31:0] read_data;
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  reg_dest;
  } memwb_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory req/ack port between the memory stage (master) and the memory (slave).
interface mem_wb_stage_if #(parameter int unsigned AW = 32);
  logic          oMemReq;
  logic          oMemWe;
  logic [AW-1:0] oMemAddr;
  logic [31:0]   oMemWData;
  logic [3:0]    oMemBe;
  logic [31:0]   iMemRData;
  logic          iMemAck;

  modport master (output oMemReq, oMemWe, oMemAddr, oMemWData, oMemBe,
                  input  iMemRData, iMemAck);
  modport slave  (input  oMemReq, oMemWe, oMemAddr, oMemWData, oMemBe,
                  output iMemRData, iMemAck);
endinterface

// File: rtl/mem_lane_align.sv
// Combinational sub-word lane handling: store replication / byte enables and load extraction.
module mem_lane_align
  import mips_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be_c,
  output logic [31:0] o_wdata_c,
  output logic [31:0] o_rdata_c
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte    = 8'(i_rdata >> {i_addr, 3'b000});
    w_half    = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_be_c    = BE_WORD;
    o_wdata_c = i_store_data;
    o_rdata_c = i_rdata;
    case (i_op)
      OP_SB: begin
        o_be_c    = 4'b0001 << i_addr;
        o_wdata_c = {4{i_store_data[7:0]}};
      end
      OP_SH: begin
        o_be_c    = i_addr[1] ? BE_HI_HALF : BE_LO_HALF;
        o_wdata_c = {2{i_store_data[15:0]}};
      end
      OP_LB:   o_rdata_c = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_rdata_c = {24'd0, w_byte};
      OP_LH:   o_rdata_c = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_rdata_c = {16'd0, w_half};
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage + MEM/WB register: branch redirect, req/ack data-memory access, write-back payload.
// Define SUBWORD_EN for byte/halfword loads and stores (mem_lane_align); default is word-only.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic [DW-1:0] iIR,
  input  logic [DW-1:0] iPC,
  input  logic [DW-1:0] iResult,
  input  logic [DW-1:0] iStoreData,
  input  logic [DW-1:0] iBranch,
  input  logic [DW-1:0] iJump,
  input  logic          iZero,
  input  logic          iBranchs,
  input  logic          iJumps,
  input  logic          iRegWrite,
  input  logic          iMemRead,
  input  logic          iMemWrite,
  input  logic          iMemToReg,
  input  logic [4:0]    iRegDest,
  mem_wb_stage_if.master dmem,
  output logic          oStall,
  output logic          oPCSrc,
  output logic [DW-1:0] oPCTarget,
  output logic [DW-1:0] oIR,
  output logic [DW-1:0] oPC,
  output logic [DW-1:0] oResult,
  output logic [DW-1:0] oReadData,
  output logic          oRegWrite,
  output logic          oMemToReg,
  output logic [4:0]    oRegDest
);
  state_t        r_state, w_state_nxt;
  logic          r_req, r_we;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata, r_rbuf;
  logic [3:0]    r_be;
  memwb_t        r_wb, w_wb_nxt;

  logic          w_mem_op, w_is_read;
  logic          w_start, w_done, w_load, w_buf, w_use_buf;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata, w_rdata_ext, w_rdata_sel;

  assign w_mem_op  = iMemRead | iMemWrite;
  assign w_is_read = iMemRead & ~iMemWrite;

`ifdef SUBWORD_EN
  mem_lane_align u_align (
    .i_op         (iIR[31:26]),
    .i_addr       (iResult[1:0]),
    .i_store_data (iStoreData),
    .i_rdata      (dmem.iMemRData),
    .o_be_c       (w_be),
    .o_wdata_c    (w_wdata),
    .o_rdata_c    (w_rdata_ext)
  );
`else
  assign w_be        = BE_WORD;
  assign w_wdata     = iStoreData;
  assign w_rdata_ext = dmem.iMemRData;
`endif

  // A write wins when both read and write are flagged, so no load data is returned.
  assign w_rdata_sel = w_is_read ? w_rdata_ext : 32'd0;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_load      = 1'b0;
    w_buf       = 1'b0;
    w_use_buf   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op) begin
          if (enable) begin
            w_state_nxt = S_ACCESS;
            w_start     = 1'b1;
          end
        end else if (enable) begin
          w_load = 1'b1;
        end
      end
      S_ACCESS: begin
        if (dmem.iMemAck) begin
          w_done = 1'b1;
          if (enable) begin
            w_state_nxt = S_IDLE;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_HOLD;
            w_buf       = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (enable) begin
          w_state_nxt = S_IDLE;
          w_load      = 1'b1;
          w_use_buf   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_wb_nxt            = r_wb;
    w_wb_nxt.ir         = 32'(iIR);
    w_wb_nxt.pc         = 32'(iPC);
    w_wb_nxt.result     = 32'(iResult);
    w_wb_nxt.read_data  = w_use_buf ? r_rbuf : w_rdata_sel;
    w_wb_nxt.reg_write  = iRegWrite;
    w_wb_nxt.mem_to_reg = iMemToReg;
    w_wb_nxt.reg_dest   = iRegDest;
  end

  // Request fields are frozen from the start edge until the ack edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rbuf  <= '0;
      r_wb    <= '0;
    end else begin
      if (w_start) begin
        r_req   <= 1'b1;
        r_we    <= iMemWrite;
        r_addr  <= {iResult[AW-1:2], 2'b00};
        r_wdata <= w_wdata;
        r_be    <= w_be;
      end else if (w_done) begin
        r_req <= 1'b0;
        r_we  <= 1'b0;
      end
      if (w_buf)  r_rbuf <= w_rdata_sel;
      if (w_load) r_wb   <= w_wb_nxt;
    end
  end

  assign oStall    = ((r_state != S_IDLE) | w_mem_op) & ~w_load;
  assign oPCSrc    = ~oStall & ((iBranchs & iZero) | iJumps);
  assign oPCTarget = iJumps ? iJump : iBranch;

  assign dmem.oMemReq   = r_req;
  assign dmem.oMemWe    = r_we;
  assign dmem.oMemAddr  = r_addr;
  assign dmem.oMemWData = r_wdata;
  assign dmem.oMemBe    = r_be;

  assign oIR       = DW'(r_wb.ir);
  assign oPC       = DW'(r_wb.pc);
  assign oResult   = DW'(r_wb.result);
  assign oReadData = DW'(r_wb.read_data);
  assign oRegWrite = r_wb.reg_write;
  assign oMemToReg = r_wb.mem_to_reg;
  assign oRegDest  = r_wb.reg_dest;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized self-checking bench for mem_wb_stage against a transaction-level reference model.
module tb_mem_wb_stage;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset, enable;
  logic [31:0] iIR, iPC, iResult, iStoreData, iBranch, iJump;
  logic        iZero, iBranchs, iJumps, iRegWrite, iMemRead, iMemWrite, iMemToReg;
  logic [4:0]  iRegDest;
  logic        oStall, oPCSrc, oRegWrite, oMemToReg;
  logic [31:0] oPCTarget, oIR, oPC, oResult, oReadData;
  logic [4:0]  oRegDest;

  mem_wb_stage_if #(.AW(32)) dmem ();

  mem_wb_stage #(.AW(32), .DW(32)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .iIR(iIR), .iPC(iPC), .iResult(iResult), .iStoreData(iStoreData),
    .iBranch(iBranch), .iJump(iJump), .iZero(iZero), .iBranchs(iBranchs),
    .iJumps(iJumps), .iRegWrite(iRegWrite), .iMemRead(iMemRead),
    .iMemWrite(iMemWrite), .iMemToReg(iMemToReg), .iRegDest(iRegDest),
    .dmem(dmem),
    .oStall(oStall), .oPCSrc(oPCSrc), .oPCTarget(oPCTarget),
    .oIR(oIR), .oPC(oPC), .oResult(oResult), .oReadData(oReadData),
    .oRegWrite(oRegWrite), .oMemToReg(oMemToReg), .oRegDest(oRegDest)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  logic [134:0] exp_wb;

  function automatic logic [134:0] wb_now();
    return {oIR, oPC, oResult, oReadData, oRegWrite, oMemToReg, oRegDest};
  endfunction

  // Reference: what a retiring load writes back.
  function automatic logic [31:0] m_load(input logic [31:0] ir, input logic [31:0] addr,
                                         input logic [31:0] rdata, input logic rd, input logic wr);
    int sh;
    logic [7:0]  b;
    logic [15:0] h;
    if (!rd || wr) return 32'h0;
    sh = 8 * int'(addr[1:0]);
    b  = 8'(rdata >> sh);
    h  = addr[1] ? rdata[31:16] : rdata[15:0];
`ifdef SUBWORD_EN
    if (ir[31:26] == OP_LB)  return {{24{b[7]}}, b};
    if (ir[31:26] == OP_LBU) return {24'd0, b};
    if (ir[31:26] == OP_LH)  return {{16{h[15]}}, h};
    if (ir[31:26] == OP_LHU) return {16'd0, h};
`else
    if (ir === 32'hx && b === 8'hx && h === 16'hx) return 32'h0;
`endif
    return rdata;
  endfunction

  function automatic logic [35:0] m_store(input logic [31:0] ir, input logic [31:0] addr,
                                          input logic [31:0] sd);
    logic [3:0] be;
    be = 4'hF;
`ifdef SUBWORD_EN
    if (ir[31:26] == OP_SB) begin
      be = 4'b0001 << addr[1:0];
      return {be, sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
    end
    if (ir[31:26] == OP_SH) begin
      be = addr[1] ? 4'hC : 4'h3;
      return {be, sd[15:0], sd[15:0]};
    end
`else
    if (ir === 32'hx && addr === 32'hx) be = 4'h0;
`endif
    return {be, sd};
  endfunction

  task automatic set_nop();
    iIR = 32'h0; iPC = 32'h0; iResult = 32'h0; iStoreData = 32'h0;
    iBranch = 32'h0; iJump = 32'h0; iZero = 1'b0; iBranchs = 1'b0; iJumps = 1'b0;
    iRegWrite = 1'b0; iMemRead = 1'b0; iMemWrite = 1'b0; iMemToReg = 1'b0; iRegDest = 5'd0;
  endtask

  // Drive the instruction currently on the inputs through the stage (called at a negedge).
  task automatic run_op(input int wait_n, input int hold_n, input logic [31:0] rdata,
                        input logic stray_ack);
    logic         mem_op, exp_src, st;
    logic [31:0]  exp_tgt;
    logic [35:0]  st_exp;
    logic [134:0] prev, want;
    mem_op  = iMemRead | iMemWrite;
    exp_src = (iBranchs & iZero) | iJumps;
    exp_tgt = iJumps ? iJump : iBranch;
    st_exp  = m_store(iIR, iResult, iStoreData);
    prev    = exp_wb;
    want    = {iIR, iPC, iResult, m_load(iIR, iResult, rdata, iMemRead, iMemWrite),
               iRegWrite, iMemToReg, iRegDest};
    enable = 1'b1;
    dmem.iMemAck = mem_op ? 1'b0 : stray_ack;
    #1;
    n_checks++;
    if (oPCTarget !== exp_tgt) begin
      n_errors++; $display("FAIL pc_target got %h exp %h", oPCTarget, exp_tgt);
    end
    n_checks++;
    if ({oStall, oPCSrc} !== {mem_op, ~mem_op & exp_src}) begin
      n_errors++; $display("FAIL issue_stall_pcsrc got %b exp %b", {oStall, oPCSrc}, {mem_op, ~mem_op & exp_src});
    end
    @(posedge clock);
    if (mem_op) begin
      for (int k = 0; k <= wait_n; k++) begin
        @(negedge clock);
        if (k == wait_n) begin
          dmem.iMemAck = 1'b1; dmem.iMemRData = rdata; enable = (hold_n == 0);
        end
        #1;
        st = !(k == wait_n && hold_n == 0);
        n_checks++;
        if ({dmem.oMemReq, dmem.oMemWe, dmem.oMemAddr, dmem.oMemBe, dmem.oMemWData} !==
            {1'b1, iMemWrite, iResult[31:2], 2'b00, st_exp}) begin
          n_errors++;
          $display("FAIL mem_request got req=%b we=%b addr=%h be=%h wd=%h exp we=%b addr=%h be/wd=%h",
                   dmem.oMemReq, dmem.oMemWe, dmem.oMemAddr, dmem.oMemBe, dmem.oMemWData,
                   iMemWrite, {iResult[31:2], 2'b00}, st_exp);
        end
        n_checks++;
        if ({oStall, oPCSrc} !== {st, ~st & exp_src}) begin
          n_errors++; $display("FAIL access_stall_pcsrc got %b exp %b", {oStall, oPCSrc}, {st, ~st & exp_src});
        end
        @(posedge clock);
      end
      #1;
      dmem.iMemAck = 1'b0;
      dmem.iMemRData = $urandom;
      for (int k = 1; k <= hold_n; k++) begin
        @(negedge clock);
        enable = (k == hold_n);
        #1;
        st = (k != hold_n);
        n_checks++;
        if ({oStall, oPCSrc, dmem.oMemReq} !== {st, ~st & exp_src, 1'b0} || wb_now() !== prev) begin
          n_errors++;
          $display("FAIL hold_state got stall=%b pcsrc=%b req=%b wb=%h exp stall=%b wb=%h",
                   oStall, oPCSrc, dmem.oMemReq, wb_now(), st, prev);
        end
        @(posedge clock);
      end
    end
    #1;
    dmem.iMemAck = 1'b0;
    exp_wb = want;
    n_checks++;
    if (wb_now() !== want) begin
      n_errors++; $display("FAIL memwb_load got %h exp %h", wb_now(), want);
    end
  endtask

  task automatic test_reset();
    set_nop(); reset = 1'b1; enable = 1'b0;
    dmem.iMemAck = 1'b0; dmem.iMemRData = 32'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    exp_wb = '0;
    n_checks++;
    if ({dmem.oMemReq, dmem.oMemWe, dmem.oMemAddr, dmem.oMemWData, dmem.oMemBe, oStall} !== 71'd0 ||
        wb_now() !== 135'd0) begin
      n_errors++; $display("FAIL reset_state got req=%b wb=%h stall=%b exp all zero", dmem.oMemReq, wb_now(), oStall);
    end
    reset = 1'b0;
  endtask

  task automatic test_alu();
    @(negedge clock);
    set_nop(); iIR = 32'h0000_1020; iPC = 32'h0000_0010; iResult = 32'h1234;
    iRegDest = 5'd5; iRegWrite = 1'b1;
    run_op(0, 0, 32'h0, 1'b0);
  endtask

  task automatic test_lw();
    @(negedge clock);
    set_nop(); iIR = {OP_LW, 26'h0}; iPC = 32'h14; iResult = 32'h40;
    iMemRead = 1'b1; iMemToReg = 1'b1; iRegWrite = 1'b1; iRegDest = 5'd8;
    run_op(3, 0, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_sw();
    @(negedge clock);
    set_nop(); iIR = {OP_SW, 26'h0}; iPC = 32'h18; iResult = 32'h44;
    iStoreData = 32'hCAFEF00D; iMemWrite = 1'b1; iRegWrite = 1'b1; iRegDest = 5'd3;
    run_op(1, 0, 32'h1111_2222, 1'b0);
  endtask

  task automatic test_branch();
    @(negedge clock);
    set_nop(); iBranchs = 1'b1; iZero = 1'b1; iBranch = 32'h100; iJumps = 1'b1; iJump = 32'h200;
    run_op(0, 0, 32'h0, 1'b0);
    @(negedge clock);
    iJumps = 1'b0;
    run_op(0, 0, 32'h0, 1'b0);
    @(negedge clock);
    iZero = 1'b0;
    run_op(0, 0, 32'h0, 1'b0);
  endtask

  task automatic test_ack_hold();
    @(negedge clock);
    set_nop(); iIR = {OP_LW, 26'h0}; iPC = 32'h20; iResult = 32'h48;
    iMemRead = 1'b1; iMemToReg = 1'b1; iRegWrite = 1'b1; iRegDest = 5'd9;
    run_op(1, 2, 32'h5A5A_1234, 1'b0);
  endtask

  task automatic test_idle_hold();
    @(negedge clock);
    set_nop(); iResult = 32'h7777; iRegWrite = 1'b1; iRegDest = 5'd7; enable = 1'b0;
    #1;
    n_checks++;
    if (oStall !== 1'b0) begin n_errors++; $display("FAIL idle_hold_stall got %b exp 0", oStall); end
    @(posedge clock); #1;
    n_checks++;
    if (wb_now() !== exp_wb) begin n_errors++; $display("FAIL idle_hold_wb got %h exp %h", wb_now(), exp_wb); end
    @(negedge clock);
    iMemRead = 1'b1;
    #1;
    n_checks++;
    if (oStall !== 1'b1) begin n_errors++; $display("FAIL idle_hold_memstall got %b exp 1", oStall); end
    @(posedge clock); #1;
    n_checks++;
    if (dmem.oMemReq !== 1'b0) begin n_errors++; $display("FAIL idle_hold_noreq got %b exp 0", dmem.oMemReq); end
    @(negedge clock);
    set_nop(); enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    set_nop(); iResult = 32'h80; iMemRead = 1'b1; iRegWrite = 1'b1; iRegDest = 5'd4; enable = 1'b1;
    @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (dmem.oMemReq !== 1'b1) begin n_errors++; $display("FAIL mid_req_before got %b exp 1", dmem.oMemReq); end
    reset = 1'b1;
    @(posedge clock); #1;
    exp_wb = '0;
    n_checks++;
    if (dmem.oMemReq !== 1'b0 || wb_now() !== exp_wb) begin
      n_errors++; $display("FAIL mid_reset got req=%b wb=%h exp req=0 wb=0", dmem.oMemReq, wb_now());
    end
    @(negedge clock);
    reset = 1'b0; set_nop(); enable = 1'b0; dmem.iMemAck = 1'b1; dmem.iMemRData = 32'hBAD0_BAD0;
    @(posedge clock); #1;
    dmem.iMemAck = 1'b0;
    n_checks++;
    if ({dmem.oMemReq, oStall} !== 2'b00 || wb_now() !== exp_wb) begin
      n_errors++; $display("FAIL late_ack got req=%b stall=%b wb=%h exp 0 0 %h", dmem.oMemReq, oStall, wb_now(), exp_wb);
    end
  endtask

`ifdef SUBWORD_EN
  task automatic test_subword();
    @(negedge clock);
    set_nop(); iIR = {OP_LB, 26'h0}; iResult = 32'h43; iMemRead = 1'b1; iRegDest = 5'd2;
    run_op(1, 0, 32'h80FF_FFFF, 1'b0);
    n_checks++;
    if (oReadData !== 32'hFFFF_FF80) begin n_errors++; $display("FAIL lb_sext got %h exp ffffff80", oReadData); end
    @(negedge clock);
    iIR = {OP_LBU, 26'h0};
    run_op(0, 0, 32'h80FF_FFFF, 1'b0);
    n_checks++;
    if (oReadData !== 32'h0000_0080) begin n_errors++; $display("FAIL lbu_zext got %h exp 00000080", oReadData); end
    @(negedge clock);
    set_nop(); iIR = {OP_SB, 26'h0}; iResult = 32'h41; iStoreData = 32'h0000_00A5; iMemWrite = 1'b1;
    run_op(0, 0, 32'h0, 1'b0);
    @(negedge clock);
    set_nop(); iIR = {OP_LH, 26'h0}; iResult = 32'h46; iMemRead = 1'b1;
    run_op(2, 1, 32'h9ABC_1234, 1'b0);
  endtask
`endif

  task automatic test_random();
    logic [5:0] ops [8];
    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
    for (int n = 0; n < 60; n++) begin
      int kind;
      @(negedge clock);
      kind = int'($urandom_range(0, 3));
      iIR = $urandom; iIR[31:26] = ops[$urandom_range(0, 7)];
      iPC = $urandom; iResult = $urandom; iStoreData = $urandom;
      iBranch = $urandom; iJump = $urandom;
      iZero = 1'($urandom); iBranchs = 1'($urandom); iJumps = 1'($urandom);
      iRegWrite = 1'($urandom); iMemToReg = 1'($urandom); iRegDest = 5'($urandom);
      iMemRead = (kind == 1) || (kind == 3);
      iMemWrite = (kind == 2) || (kind == 3);
      run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lw();
    test_sw();
    test_branch();
    test_ack_hold();
    test_idle_hold();
    test_reset_mid();
`ifdef SUBWORD_EN
    test_subword();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
